// File: rtl/axi_mem_arbiter.sv
// Two-port (instruction/data) arbiter onto a single-beat AXI4 master with round-robin
// grant, one outstanding transaction, and per-state handshake timeout.
module axi_mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    // port 0: instruction side, read only
    input  logic        req0,
    input  logic [31:0] addr0,
    output logic        done0,
    output logic        err0,
    output logic [31:0] rdata0,
    // port 1: data side, read or write
    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    input  logic [3:0]  wstrb1,
    output logic        done1,
    output logic        err1,
    output logic [31:0] rdata1,
    // AXI4 read channels
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    // AXI4 write channels
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    // fixed single-beat burst attributes
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [3:0]  arcache,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [3:0]  awcache
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WRITE, WRESP, DONE} state_e;

    state_e        state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          port_q, port_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic          aw_ok_q, aw_ok_d;
    logic          w_ok_q, w_ok_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [31:0]   xrdata_q, xrdata_d;
    logic          xerr_q, xerr_d;
    logic          done0_q, done0_d, done1_q, done1_d;
    logic          err0_q, err0_d, err1_q, err1_d;
    logic [31:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic grant;
    logic tmo_hit;
    logic aw_acc, w_acc;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned
    // (an unassigned path in always_comb would infer a latch).
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        port_d       = port_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        aw_ok_d      = aw_ok_q;
        w_ok_d       = w_ok_q;
        xrdata_d     = xrdata_q;
        xerr_d       = xerr_q;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        err0_d       = err0_q;
        err1_d       = err1_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        grant        = 1'b0;
        aw_acc       = aw_ok_q | awready;
        w_acc        = w_ok_q | wready;
        tmo_hit      = (tmo_q == TW'(TIMEOUT - 1));

        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // on a tie, the port that did not win last time goes first
                    grant        = (req0 && req1) ? ~last_grant_q : req1;
                    last_grant_d = grant;
                    port_d       = grant;
                    we_d         = grant & we1;
                    addr_d       = grant ? addr1  : addr0;
                    wdata_d      = grant ? wdata1 : '0;
                    wstrb_d      = grant ? wstrb1 : '0;
                    aw_ok_d      = 1'b0;
                    w_ok_d       = 1'b0;
                    state_d      = (grant && we1) ? WRITE : RADDR;
                end
            end
            RADDR: begin
                if (arready)      state_d = RDATA;
                else if (tmo_hit) state_d = DONE;
            end
            RDATA: begin
                if (rvalid) begin
                    xrdata_d = rdata;
                    xerr_d   = (rresp != 2'b00) || !rlast;
                    state_d  = DONE;
                end else if (tmo_hit) begin
                    state_d = DONE;
                end
            end
            WRITE: begin
                aw_ok_d = aw_acc;
                w_ok_d  = w_acc;
                if (aw_acc && w_acc) state_d = WRESP;
                else if (tmo_hit)    state_d = DONE;
            end
            WRESP: begin
                if (bvalid) begin
                    xrdata_d = '0;
                    xerr_d   = (bresp != 2'b00);
                    state_d  = DONE;
                end else if (tmo_hit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (port_q) begin
                    done1_d  = 1'b1;
                    err1_d   = xerr_q;
                    rdata1_d = xrdata_q;
                end else begin
                    done0_d  = 1'b1;
                    err0_d   = xerr_q;
                    rdata0_d = xrdata_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // a timeout abort overrides whatever the state captured
        if (tmo_hit && state_d == DONE && state_q != DONE &&
            !(state_q == RDATA && rvalid) && !(state_q == WRESP && bvalid)) begin
            xrdata_d = '0;
            xerr_d   = 1'b1;
        end

        tmo_d = '0;
        if (state_d == state_q && state_q != IDLE && state_q != DONE) tmo_d = tmo_q + TW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            port_q       <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            aw_ok_q      <= 1'b0;
            w_ok_q       <= 1'b0;
            tmo_q        <= '0;
            xrdata_q     <= '0;
            xerr_q       <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            aw_ok_q      <= aw_ok_d;
            w_ok_q       <= w_ok_d;
            tmo_q        <= tmo_d;
            xrdata_q     <= xrdata_d;
            xerr_q       <= xerr_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign done0   = done0_q;
    assign err0    = err0_q;
    assign rdata0  = rdata0_q;
    assign done1   = done1_q;
    assign err1    = err1_q;
    assign rdata1  = rdata1_q;

    assign araddr  = addr_q;
    assign arvalid = (state_q == RADDR);
    assign rready  = (state_q == RDATA);
    assign awaddr  = addr_q;
    assign awvalid = (state_q == WRITE) && !aw_ok_q;
    assign wvalid  = (state_q == WRITE) && !w_ok_q;
    assign wlast   = wvalid;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign bready  = (state_q == WRESP);

    assign arlen   = 8'd0;
    assign arsize  = 3'd2;
    assign arburst = 2'b01;
    assign arcache = 4'd7;
    assign awlen   = 8'd0;
    assign awsize  = 3'd2;
    assign awburst = 2'b01;
    assign awcache = 4'd11;

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed bench for axi_mem_arbiter: negedge-driven AXI slave, negedge monitor,
// one task per scenario with inline expected-value comparisons.
module tb_axi_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, done0, err0;
    logic [31:0] addr0, rdata0;
    logic        req1, we1, done1, err1;
    logic [31:0] addr1, wdata1, rdata1;
    logic [3:0]  wstrb1;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [1:0]  rresp, bresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb, arcache, awcache;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst;

    int checks = 0;
    int failures = 0;

    // slave configuration
    logic        cfg_arready, cfg_awready, cfg_r_en, cfg_b_en, cfg_rlast;
    logic [1:0]  cfg_rresp, cfg_bresp;
    logic [31:0] cfg_rdata;
    int          cfg_wdelay;
    int          w_wait;

    // monitor records
    int          arv_cyc, awv_cyc, wv_cyc, ar_hs, aw_hs, w_hs;
    int          done0_cnt, done1_cnt, overlap_cnt, both_done_cnt;
    logic [31:0] ar_addr_log, aw_addr_log, w_data_log;
    logic [3:0]  w_strb_log;
    logic        w_last_log;

    axi_mem_arbiter #(.TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .addr0(addr0), .done0(done0), .err0(err0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .wstrb1(wstrb1),
        .done1(done1), .err1(err1), .rdata1(rdata1),
        .araddr(araddr), .arvalid(arvalid), .arready(arready), .rdata(rdata),
        .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .wdata(wdata),
        .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arlen(arlen), .arsize(arsize), .arburst(arburst), .arcache(arcache),
        .awlen(awlen), .awsize(awsize), .awburst(awburst), .awcache(awcache)
    );

    always #5 clk = ~clk;

    // slave responds on the falling edge so its outputs are stable at the next rising edge
    always @(negedge clk) begin
        arready = cfg_arready;
        awready = cfg_awready;
        rvalid  = rready && cfg_r_en;
        rdata   = cfg_rdata;
        rresp   = cfg_rresp;
        rlast   = cfg_rlast;
        bvalid  = bready && cfg_b_en;
        bresp   = cfg_bresp;
        if (wvalid) begin
            wready = (w_wait >= cfg_wdelay);
            w_wait++;
        end else begin
            wready = 1'b0;
            w_wait = 0;
        end
    end

    // records handshakes that will complete at the coming rising edge
    always @(negedge clk) begin
        #1;
        if (arvalid) arv_cyc++;
        if (awvalid) awv_cyc++;
        if (wvalid)  wv_cyc++;
        if (arvalid && arready) begin ar_hs++; ar_addr_log = araddr; end
        if (awvalid && awready) begin aw_hs++; aw_addr_log = awaddr; end
        if (wvalid && wready) begin
            w_hs++; w_data_log = wdata; w_strb_log = wstrb; w_last_log = wlast;
        end
        if (done0) done0_cnt++;
        if (done1) done1_cnt++;
        if (done0 && done1) both_done_cnt++;
        if ((arvalid || rready) && (awvalid || wvalid || bready)) overlap_cnt++;
    end

    task automatic clear_logs();
        arv_cyc = 0; awv_cyc = 0; wv_cyc = 0; ar_hs = 0; aw_hs = 0; w_hs = 0;
        done0_cnt = 0; done1_cnt = 0; overlap_cnt = 0; both_done_cnt = 0;
    endtask

    task automatic pulse_reset();
        @(negedge clk); #2;
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        rst_n = 1'b1;
    endtask

    // Runs one request on a port; lat = rising edges from req to visible done, -1 if none.
    // The requester inputs are disturbed right after grant; the latched request must win.
    task automatic do_xfer(input bit port, input bit we, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] ws,
                           output int lat, output logic [31:0] rd, output logic er);
        lat = -1; rd = 'x; er = 'x;
        @(negedge clk); #2;
        if (port == 1'b0) begin
            addr0 = addr; req0 = 1'b1;
        end else begin
            addr1 = addr; we1 = we; wdata1 = wd; wstrb1 = ws; req1 = 1'b1;
        end
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk); #2;
            if (c == 1) begin
                addr0 = 32'hFFFF_0999; addr1 = 32'hFFFF_0999;
                wdata1 = 32'h5555_5555; wstrb1 = 4'h0; we1 = ~we;
            end
            if ((port == 1'b0 && done0) || (port == 1'b1 && done1)) begin
                lat = c;
                rd  = port ? rdata1 : rdata0;
                er  = port ? err1 : err0;
                break;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_reset();
        pulse_reset();
        checks++;
        if ({arvalid, rready, awvalid, wvalid, wlast, bready, done0, done1, err0, err1} !== 10'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=0000000000",
                     {arvalid, rready, awvalid, wvalid, wlast, bready, done0, done1, err0, err1});
        end
        checks++;
        if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
            failures++; $display("FAIL reset_rdata got=%h/%h want=0/0", rdata0, rdata1);
        end
        checks++;
        if ({arlen, arsize, arburst, arcache, awlen, awsize, awburst, awcache} !==
            {8'd0, 3'd2, 2'b01, 4'd7, 8'd0, 3'd2, 2'b01, 4'd11}) begin
            failures++;
            $display("FAIL axi_consts got ar=%h/%h/%h/%h aw=%h/%h/%h/%h want 0/2/1/7 0/2/1/b",
                     arlen, arsize, arburst, arcache, awlen, awsize, awburst, awcache);
        end
    endtask

    task automatic test_read_basic();
        int lat; logic [31:0] rd; logic er;
        cfg_rdata = 32'hDEAD_BEEF;
        clear_logs();
        do_xfer(1'b0, 1'b0, 32'h0000_0100, '0, '0, lat, rd, er);
        checks++;
        if (lat !== 4) begin failures++; $display("FAIL read_latency got=%0d want=4", lat); end
        checks++;
        if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
            failures++; $display("FAIL read_data got=%h err=%b want=deadbeef err=0", rd, er);
        end
        checks++;
        if (ar_hs !== 1 || ar_addr_log !== 32'h0000_0100) begin
            failures++; $display("FAIL read_araddr got=%h hs=%0d want=00000100 hs=1", ar_addr_log, ar_hs);
        end
        checks++;
        if (done1_cnt !== 0 || done0_cnt !== 1) begin
            failures++; $display("FAIL read_done_port got d0=%0d d1=%0d want d0=1 d1=0", done0_cnt, done1_cnt);
        end
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if (done0 !== 1'b0 || rdata0 !== 32'hDEAD_BEEF || err0 !== 1'b0) begin
            failures++; $display("FAIL read_hold got done=%b rdata=%h err=%b want 0/deadbeef/0", done0, rdata0, err0);
        end
    endtask

    task automatic test_write_wait();
        int lat; logic [31:0] rd; logic er;
        cfg_wdelay = 3;
        clear_logs();
        do_xfer(1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678, 4'hF, lat, rd, er);
        cfg_wdelay = 0;
        checks++;
        if (lat !== 7 || er !== 1'b0 || rd !== 32'h0) begin
            failures++; $display("FAIL write_done got lat=%0d err=%b rdata=%h want 7/0/0", lat, er, rd);
        end
        checks++;
        if (awv_cyc !== 1 || wv_cyc !== 4) begin
            failures++; $display("FAIL write_valid_cycles got aw=%0d w=%0d want aw=1 w=4", awv_cyc, wv_cyc);
        end
        checks++;
        if (aw_addr_log !== 32'h0000_0200 || w_data_log !== 32'h1234_5678 ||
            w_strb_log !== 4'hF || w_last_log !== 1'b1) begin
            failures++;
            $display("FAIL write_beat got addr=%h data=%h strb=%h last=%b want 00000200/12345678/f/1",
                     aw_addr_log, w_data_log, w_strb_log, w_last_log);
        end
    endtask

    task automatic test_errors();
        int lat; logic [31:0] rd; logic er;
        clear_logs();
        cfg_bresp = 2'b10;
        do_xfer(1'b1, 1'b1, 32'h0000_0208, 32'h0BAD_F00D, 4'h3, lat, rd, er);
        cfg_bresp = 2'b00;
        checks++;
        if (lat !== 4 || er !== 1'b1) begin
            failures++; $display("FAIL write_bresp_err got lat=%0d err=%b want 4/1", lat, er);
        end
        checks++;
        if (w_strb_log !== 4'h3 || w_data_log !== 32'h0BAD_F00D) begin
            failures++; $display("FAIL write_strb got strb=%h data=%h want 3/0badf00d", w_strb_log, w_data_log);
        end
        cfg_rresp = 2'b11; cfg_rdata = 32'h1111_2222;
        do_xfer(1'b0, 1'b0, 32'h0000_010C, '0, '0, lat, rd, er);
        cfg_rresp = 2'b00;
        checks++;
        if (er !== 1'b1 || rd !== 32'h1111_2222) begin
            failures++; $display("FAIL read_rresp_err got err=%b rdata=%h want 1/11112222", er, rd);
        end
        cfg_rlast = 1'b0;
        do_xfer(1'b0, 1'b0, 32'h0000_0110, '0, '0, lat, rd, er);
        cfg_rlast = 1'b1;
        checks++;
        if (er !== 1'b1) begin failures++; $display("FAIL read_rlast_err got err=%b want 1", er); end
        cfg_rdata = 32'h3333_4444;
        do_xfer(1'b0, 1'b0, 32'h0000_0114, '0, '0, lat, rd, er);
        checks++;
        if (er !== 1'b0 || rd !== 32'h3333_4444) begin
            failures++; $display("FAIL read_err_clear got err=%b rdata=%h want 0/33334444", er, rd);
        end
        checks++;
        if (err1 !== 1'b1) begin failures++; $display("FAIL err1_hold got=%b want 1", err1); end
    endtask

    task automatic test_timeout();
        int lat; logic [31:0] rd; logic er;
        cfg_arready = 1'b0;
        clear_logs();
        do_xfer(1'b0, 1'b0, 32'h0000_0180, '0, '0, lat, rd, er);
        cfg_arready = 1'b1;
        checks++;
        if (lat !== 10 || er !== 1'b1 || rd !== 32'h0) begin
            failures++; $display("FAIL ar_timeout got lat=%0d err=%b rdata=%h want 10/1/0", lat, er, rd);
        end
        checks++;
        if (arv_cyc !== 8 || ar_hs !== 0 || arvalid !== 1'b0) begin
            failures++; $display("FAIL ar_timeout_valid got cyc=%0d hs=%0d arvalid=%b want 8/0/0", arv_cyc, ar_hs, arvalid);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] rd; logic er;
        cfg_rdata = 32'h7777_8888;
        do_xfer(1'b1, 1'b0, 32'h0000_0600, '0, '0, lat, rd, er);
        checks++;
        if (lat !== 4 || rd !== 32'h7777_8888 || er !== 1'b0 || rdata0 !== 32'h0) begin
            failures++;
            $display("FAIL port1_read got lat=%0d rdata1=%h err1=%b rdata0=%h want 4/77778888/0/0", lat, rd, er, rdata0);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd; logic er; bit seen;
        cfg_r_en = 1'b0;
        clear_logs();
        seen = 1'b0;
        @(negedge clk); #2;
        addr0 = 32'h0000_0300; req0 = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #2;
            if (rready) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL reach_rdata got rready=%b want 1", rready); end
        rst_n = 1'b0;
        @(negedge clk); #2;
        req0 = 1'b0;
        checks++;
        if (rready !== 1'b0 || arvalid !== 1'b0) begin
            failures++; $display("FAIL mid_reset_rready got rready=%b arvalid=%b want 0/0", rready, arvalid);
        end
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        cfg_r_en = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        checks++;
        if (done0_cnt !== 0 || rdata0 !== 32'h0 || ar_hs !== 1) begin
            failures++; $display("FAIL mid_reset_no_done got done=%0d rdata0=%h ar=%0d want 0/0/1", done0_cnt, rdata0, ar_hs);
        end
        cfg_rdata = 32'hCAFE_F00D;
        do_xfer(1'b0, 1'b0, 32'h0000_0340, '0, '0, lat, rd, er);
        checks++;
        if (lat !== 4 || rd !== 32'hCAFE_F00D || er !== 1'b0 || ar_addr_log !== 32'h0000_0340) begin
            failures++;
            $display("FAIL post_reset_read got lat=%0d rdata=%h err=%b addr=%h want 4/cafef00d/0/00000340",
                     lat, rd, er, ar_addr_log);
        end
    endtask

    task automatic test_arbitration();
        int seq[3];
        int n;
        pulse_reset();
        clear_logs();
        n = 0;
        seq = '{-1, -1, -1};
        addr0 = 32'h0000_0400; addr1 = 32'h0000_0500;
        we1 = 1'b1; wdata1 = 32'hA5A5_0001; wstrb1 = 4'hF;
        for (int c = 0; c < 200 && n < 3; c++) begin
            @(negedge clk); #2;
            req0 = 1'b1; req1 = 1'b1;
            if (done0) begin seq[n] = 0; n++; req0 = 1'b0; end
            if (done1 && n < 3) begin seq[n] = 1; n++; req1 = 1'b0; end
        end
        req0 = 1'b0; req1 = 1'b0;
        checks++;
        if (n !== 3 || seq[0] !== 0 || seq[1] !== 1 || seq[2] !== 0) begin
            failures++; $display("FAIL rr_order got n=%0d seq=%0d,%0d,%0d want 3 0,1,0", n, seq[0], seq[1], seq[2]);
        end
        checks++;
        if (overlap_cnt !== 0 || both_done_cnt !== 0 || ar_hs !== 2 || aw_hs !== 1) begin
            failures++;
            $display("FAIL rr_exclusive got overlap=%0d both=%0d ar=%0d aw=%0d want 0/0/2/1",
                     overlap_cnt, both_done_cnt, ar_hs, aw_hs);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; addr0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0; wstrb1 = '0;
        arready = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bresp = '0; bvalid = 1'b0;
        cfg_arready = 1'b1; cfg_awready = 1'b1; cfg_r_en = 1'b1; cfg_b_en = 1'b1;
        cfg_rlast = 1'b1; cfg_rresp = 2'b00; cfg_bresp = 2'b00;
        cfg_rdata = 32'hDEAD_BEEF; cfg_wdelay = 0; w_wait = 0;
        ar_addr_log = '0; aw_addr_log = '0; w_data_log = '0; w_strb_log = '0; w_last_log = 1'b0;
        clear_logs();

        test_reset();
        test_read_basic();
        test_write_wait();
        test_errors();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_arbitration();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_mem_arbiter.md
AXI_MEM_ARBITER -- requirements
Module: axi_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max cycles waiting on any single AXI handshake before error abort.
REQ-002 SHALL have clk  in  1  clock; all logic rising-edge.
REQ-003 SHALL have rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have req0  in  1  port 0 (instruction side) read request, held until done0.
REQ-005 SHALL have addr0  in  32  port 0 word address.
REQ-006 SHALL have done0, err0  out  1 each  port 0 completion pulse, error flag valid with done0.
REQ-007 SHALL have rdata0  out  32  port 0 read data, valid with done0.
REQ-008 SHALL have req1, we1  in  1 each  port 1 (data side) request, write-enable (0 = read).
REQ-009 SHALL have addr1, wdata1  in  32 each  port 1 address, write data; wstrb1  in  4  byte strobes.
REQ-010 SHALL have done1, err1  out  1 each; rdata1  out  32  port 1 completion, error, read data.
REQ-011 SHALL have AXI4 master read channels: araddr out 32, arvalid out 1, arready in 1, rdata in 32, rresp in 2, rlast in 1, rvalid in 1, rready out 1.
REQ-012 SHALL have AXI4 master write channels: awaddr out 32, awvalid out 1, awready in 1, wdata out 32, wstrb out 4, wlast out 1, wvalid out 1, wready in 1, bresp in 2, bvalid in 1, bready out 1.
REQ-013 SHALL drive constant arlen/awlen = 8'd0, arsize/awsize = 3'd2, arburst/awburst = 2'b01, arcache = 4'd7, awcache = 4'd11 (never tri-stated).

Function
REQ-014 SHALL run at most one AXI transaction at a time; FSM states IDLE, RADDR, RDATA, WRITE, WRESP, DONE.
REQ-015 In IDLE, one request: grant it; both: grant the port not granted last (round-robin); last-grant register resets to port 1, so port 0 wins the first tie.
REQ-016 On grant SHALL latch port id, we, addr, wdata, wstrb into a request register; AXI outputs driven only from that register.
REQ-017 IDLE -> RADDR (read) or WRITE (write) on the cycle after the grant decision; no request: stay IDLE, all valid/ready low.
REQ-018 RADDR: arvalid=1 until arready sampled high, then -> RDATA with arvalid=0 next cycle.
REQ-019 RDATA: rready=1; on rvalid capture rdata, err = (rresp != 0) or (rlast == 0), -> DONE.
REQ-020 WRITE: awvalid and wvalid both asserted, wlast=1 with wvalid; each drops independently once its ready is seen; -> WRESP when both accepted (either order, or same cycle).
REQ-021 WRESP: bready=1; on bvalid, err = (bresp != 0), -> DONE.
REQ-022 DONE: one-cycle pulse on done of the granted port only, with rdata (reads; 0 on writes) and err; -> IDLE; requester deasserts req same cycle.
REQ-023 Minimum latency req->done with zero-wait slave: 4 cycles read, 4 cycles write.
REQ-024 Per-state timeout counter clears on state entry; reaching TIMEOUT in RADDR/RDATA/WRITE/WRESP SHALL drop all valid/ready, -> DONE with err=1 and rdata=0.
REQ-025 Request changes on a port while granted SHALL be ignored until DONE.
REQ-026 rdata0/rdata1/err0/err1 SHALL hold last values between done pulses.

Reset
REQ-027 rst_n=0 at a clock edge: state IDLE, all valid/ready/wlast=0, done0/done1/err0/err1=0, rdata0/rdata1=0, timeout counter 0, last-grant=port 1.
REQ-028 Reset mid-transaction SHALL abort without a done pulse; the next transaction starts only after rst_n=1 and a new grant.

Verification
REQ-029 Port 0 read addr0=0x100, slave arready/rvalid immediate, rdata=0xDEADBEEF, rresp=0, rlast=1 -> done0 4 cycles after req0, rdata0=0xDEADBEEF, err0=0.
REQ-030 req0 and req1 asserted together three times -> grants in order 0,1,0, never overlapping on AXI.
REQ-031 Port 1 write addr1=0x200, wdata1=0x12345678, wstrb1=0xF, wready 3 cycles after awready -> wvalid holds until wready, done1 after bvalid, err1=0.
REQ-032 Write with bresp=2'b10 -> done1 with err1=1; read with rresp=2'b11 -> err0=1.
REQ-033 arready never asserted, TIMEOUT=8 -> arvalid drops, done0 with err0=1 and rdata0=0 after 8 RADDR cycles.
REQ-034 rst_n=0 during RDATA -> rready=0 next edge, no done pulse, clean read completes after release.
